// File: rtl/key_exp_outer.sv
// AES-128/192/256 key expansion into a 15 x 128-bit round-key store with a random-access read port.
// Optional define KEY_EXP_RKEY_REG_EN registers the read port (1-cycle read latency).
module key_exp_outer (
  input  logic         clk,
  input  logic         reset,
  input  logic [255:0] short_key,
  input  logic [1:0]   aes_mode,
  input  logic [3:0]   rkey_addr,
  output logic [127:0] rkey,
  output logic         rdy
);

  typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DONE} state_t;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction

  state_t              state, state_nxt;
  logic [1:0]          mode_q;
  logic [14:0][127:0]  mem;
  logic [7:0][31:0]    win;       // win[0] = w[i-1], win[k] = w[i-1-k]
  logic [5:0]          widx;
  logic [2:0]          kcnt;      // i mod Nk
  logic [7:0]          rcon;
  logic [3:0]          nk, nr, ld_nk;
  logic [5:0]          last_idx;
  logic                do_load, do_exp;
  logic [31:0]         prev, back, sub_in, sub_out, tmp, w_new;
  logic [127:0]        rd_data;

  always_comb begin
    case (mode_q)
      2'b10:   begin nk = 4'd6; nr = 4'd12; last_idx = 6'd51; end
      2'b11:   begin nk = 4'd8; nr = 4'd14; last_idx = 6'd59; end
      default: begin nk = 4'd4; nr = 4'd10; last_idx = 6'd43; end
    endcase
    case (aes_mode)
      2'b10:   ld_nk = 4'd6;
      2'b11:   ld_nk = 4'd8;
      default: ld_nk = 4'd4;
    endcase
  end

  // FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    do_load   = 1'b0;
    do_exp    = 1'b0;
    case (state)
      IDLE: begin
        do_load   = 1'b1;
        state_nxt = LOAD;
      end
      LOAD, EXPAND: begin
        do_exp    = 1'b1;
        state_nxt = (widx == last_idx) ? DONE : EXPAND;
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next schedule word; a single SubWord serves both the RotWord and the Nk=8 mid-block cases
  always_comb begin
    prev = win[0];
    case (nk)
      4'd8:    back = win[7];
      4'd6:    back = win[5];
      default: back = win[3];
    endcase
    sub_in  = (kcnt == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
    sub_out = {sbox(sub_in[31:24]), sbox(sub_in[23:16]), sbox(sub_in[15:8]), sbox(sub_in[7:0])};
    if (kcnt == 3'd0)                     tmp = sub_out ^ {rcon, 24'h0};
    else if (nk == 4'd8 && kcnt == 3'd4)  tmp = sub_out;
    else                                  tmp = prev;
    w_new = back ^ tmp;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q <= 2'b00;
      mem    <= '0;
      win    <= '0;
      widx   <= '0;
      kcnt   <= '0;
      rcon   <= 8'h01;
    end else if (do_load) begin
      mode_q <= aes_mode;
      // right-aligned key: win[j] then holds w[Nk-1-j] for j < Nk
      win    <= short_key;
      widx   <= {2'b00, ld_nk};
      kcnt   <= '0;
      rcon   <= 8'h01;
      case (aes_mode)
        2'b11: begin
          mem[0] <= short_key[255:128];
          mem[1] <= short_key[127:0];
        end
        2'b10: begin
          mem[0]          <= short_key[191:64];
          mem[1][127:64]  <= short_key[63:0];
        end
        default: mem[0] <= short_key[127:0];
      endcase
    end else if (do_exp) begin
      mem[widx[5:2]][{~widx[1:0], 5'b00000} +: 32] <= w_new;
      win  <= {win[6:0], w_new};
      widx <= widx + 6'd1;
      kcnt <= ({1'b0, kcnt} == nk - 4'd1) ? 3'd0 : kcnt + 3'd1;
      if (kcnt == 3'd0) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
    end
  end

  // Addresses beyond Nr (including 15) read as zero
  always_comb begin
    rd_data = '0;
    if (rkey_addr <= nr) rd_data = mem[rkey_addr];
  end

`ifdef KEY_EXP_RKEY_REG_EN
  logic [127:0] rkey_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rkey_q <= '0;
    else        rkey_q <= rd_data;
  end
  assign rkey = rkey_q;
`else
  assign rkey = rd_data;
`endif

  assign rdy = (state == DONE);

endmodule

// File: tb/tb_key_exp_outer.sv
// Directed bench for key_exp_outer: scoreboard of expected round keys from an independent key-schedule model.
module tb_key_exp_outer;

  logic         clk;
  logic         reset;
  logic [255:0] short_key;
  logic [1:0]   aes_mode;
  logic [3:0]   rkey_addr;
  logic [127:0] rkey;
  logic         rdy;

  key_exp_outer dut (
    .clk       (clk),
    .reset     (reset),
    .short_key (short_key),
    .aes_mode  (aes_mode),
    .rkey_addr (rkey_addr),
    .rkey      (rkey),
    .rdy       (rdy)
  );

  localparam logic [255:0] K128 = 256'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [255:0] K192 = 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  int           n_cmp = 0;
  int           n_err = 0;
  int           ecnt;
  logic [7:0]   sbm [256];
  logic [127:0] exp_rk [16];
  logic [127:0] sb_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // edges since reset release; edge 1 is the LOAD edge
  always @(posedge clk or negedge reset) begin
    if (!reset) ecnt <= 0;
    else        ecnt <= ecnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int v = 1; v < 256; v++)
        if (gmul(8'(x), 8'(v)) == 8'h01) inv = 8'(v);
      sbm[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] v);
    return {sbm[v[31:24]], sbm[v[23:16]], sbm[v[15:8]], sbm[v[7:0]]};
  endfunction

  task automatic model(input logic [255:0] key, input logic [1:0] mode);
    int nk, nr, tot;
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    nk = (mode == 2'b11) ? 8 : (mode == 2'b10) ? 6 : 4;
    nr = nk + 6;
    tot = 4 * (nr + 1);
    for (int j = 0; j < 60; j++) w[j] = 32'h0;
    for (int j = 0; j < nk; j++) w[j] = key[32*(nk-1-j) +: 32];
    rc = 8'h01;
    for (int i = nk; i < tot; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++)
      exp_rk[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // drive address on the falling edge, compare when the read port produces it
  task automatic read_check(input int addr, input logic [127:0] expv, input string tag);
    @(negedge clk);
    rkey_addr = 4'(addr);
    sb_q.push_back(expv);
`ifdef KEY_EXP_RKEY_REG_EN
    #1;
    chk({tag, "_prelat"}, rkey === expv && expv !== 128'h0 ? 128'h1 : 128'h0, 128'h0);
    @(posedge clk);
`endif
    #1;
    chk(tag, rkey, sb_q.pop_front());
  endtask

  task automatic sweep(input string tag);
    for (int a = 0; a < 16; a++) read_check(a, exp_rk[a], $sformatf("%s_rk%0d", tag, a));
  endtask

  task automatic start_run(input logic [255:0] key, input logic [1:0] mode);
    @(negedge clk);
    reset = 1'b0;
    short_key = key;
    aes_mode = mode;
    model(key, mode);
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_rdy(input int exp_edges, input string tag);
    int n;
    n = 0;
    while (!rdy && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_rdy"}, 128'(rdy), 128'h1);
    chk({tag, "_rdy_edge"}, 128'(ecnt), 128'(exp_edges));
  endtask

  task automatic wait_edge(input int e);
    int n;
    n = 0;
    while (ecnt < e && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    reset = 1'b0;
    short_key = '0;
    aes_mode = 2'b00;
    rkey_addr = 4'd0;
    build_sbox();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rdy", 128'(rdy), 128'h0);
    chk("reset_rkey", rkey, 128'h0);
    read_check(1, 128'h0, "reset_mem1");

    // AES-128
    start_run(K128, 2'b01);
    wait_rdy(41, "a128");
    read_check(1, 128'ha0fafe1788542cb123a339392a6c7605, "a128_spec1");
    read_check(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "a128_spec10");
    sweep("a128");

    // mode 00 behaves as AES-128
    start_run(K128, 2'b00);
    wait_rdy(41, "m00");
    read_check(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "m00_spec10");
    read_check(11, 128'h0, "m00_rk11");

    // AES-192 with inputs changed after LOAD
    start_run(K192, 2'b10);
    wait_edge(2);
    @(negedge clk);
    short_key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    aes_mode = 2'b01;
    wait_rdy(47, "a192");
    read_check(1, 128'h62f8ead2522c6b7bfe0c91f72402f5a5, "a192_spec1");
    read_check(12, 128'he98ba06f448c773c8ecc720401002202, "a192_spec12");
    sweep("a192");

    // AES-256
    start_run(K256, 2'b11);
    wait_rdy(53, "a256");
    read_check(0, 128'h603deb1015ca71be2b73aef0857d7781, "a256_spec0");
    read_check(2, 128'h9ba354118e6925afa51a8b5f2067fcde, "a256_spec2");
    read_check(14, 128'hfe4890d1e6188d0b046df344706c631e, "a256_spec14");
    sweep("a256");

    // reset in the middle of an AES-256 expansion
    start_run(K256, 2'b11);
    wait_edge(17);
    read_check(5, exp_rk[5], "mid_rk5");
    read_check(10, 128'h0, "mid_rk10_unwritten");
    wait_edge(20);
    reset = 1'b0;
    #1;
    chk("abort_rdy", 128'(rdy), 128'h0);
    chk("abort_rkey", rkey, 128'h0);
    read_check(0, 128'h0, "abort_rk0");
    read_check(5, 128'h0, "abort_rk5");
    @(negedge clk);
    reset = 1'b1;
    wait_rdy(53, "rerun");
    sweep("rerun");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
